ex_mdu: RTL

EX_MDU -- requirements
Module: ex_mdu

---
 rtl/ex_mdu_pkg.sv | 47 ++++
 rtl/mdu_div.sv | 78 +++++++
 rtl/ex_mdu.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: definitions shared by the EX-stage M-extension unit and its bench.
//   - AluOp encodings. The pre-existing ALU ops are listed so that the M-op block
//     can be seen next to them.
//   - Index of the EX-stage bit in the 6-bit ctrl stall vector.
//   - MDU FSM state encoding.
//   - Helpers that classify an aluop as a multiply or a divide/remainder op.
package ex_mdu_pkg;

  // Existing AluOp encodings
  localparam logic [7:0] EXE_NOP_OP    = 8'h00;
  localparam logic [7:0] EXE_ADD_OP    = 8'h20;
  localparam logic [7:0] EXE_SUB_OP    = 8'h22;
  localparam logic [7:0] EXE_AND_OP    = 8'h24;
  localparam logic [7:0] EXE_OR_OP     = 8'h25;

  // RV32M AluOp encodings
  localparam logic [7:0] EXE_MUL_OP    = 8'hb0;
  localparam logic [7:0] EXE_MULH_OP   = 8'hb1;
  localparam logic [7:0] EXE_MULHSU_OP = 8'hb2;
  localparam logic [7:0] EXE_MULHU_OP  = 8'hb3;
  localparam logic [7:0] EXE_DIV_OP    = 8'hb4;
  localparam logic [7:0] EXE_DIVU_OP   = 8'hb5;
  localparam logic [7:0] EXE_REM_OP    = 8'hb6;
  localparam logic [7:0] EXE_REMU_OP   = 8'hb7;

  // Stall vector: bit 3 holds the EX stage
  localparam int unsigned StallEx = 3;

  // MDU FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [7:0] op);
    return (op == EXE_MUL_OP) || (op == EXE_MULH_OP) ||
           (op == EXE_MULHSU_OP) || (op == EXE_MULHU_OP);
  endfunction

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP) ||
           (op == EXE_REM_OP) || (op == EXE_REMU_OP);
  endfunction

endpackage

// File: rtl/mdu_div.sv
// mdu_div: 32-bit unsigned restoring divider, one quotient bit per cycle.
//   clk, rst   clock, synchronous active-high reset
//   start      load dividend/divisor; the 32 steps run on the following 32 edges
//   dividend   unsigned dividend (sampled when start=1)
//   divisor    unsigned divisor, must be non-zero (sampled when start=1)
//   quotient   quotient, valid after done and held until the next start
//   remainder  remainder, valid after done and held until the next start
//   done       high during the cycle whose edge performs the last step
module mdu_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic        busy_q, busy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;

  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        ge;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // rem_q < divisor, so rem_sh < 2*divisor and a 33-bit difference is enough.
  assign rem_sh = {rem_q, quo_q[31]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign ge     = (rem_sh >= {1'b0, dvs_q});

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = 5'd0;
      quo_d  = dividend;
      rem_d  = 32'd0;
      dvs_d  = divisor;
    end else if (busy_q) begin
      quo_d = {quo_q[30:0], ge};
      rem_d = ge ? diff[31:0] : rem_sh[31:0];
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= 5'd0;
      quo_q  <= 32'd0;
      rem_q  <= 32'd0;
      dvs_q  <= 32'd0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  assign done      = busy_q && (cnt_q == 5'd31);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: EX-stage RV32M unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Operands are converted to magnitudes and latched when an M op is seen in IDLE;
// the unsigned core iterates (multiplier here, divider in mdu_div) and the sign
// is restored in DONE. Divide-by-zero and signed overflow skip straight to DONE.
//   clk, rst      clock, synchronous active-high reset
//   stall[5:0]    ctrl stall vector; stall[3] holds EX (keeps DONE and its result)
//   aluop[7:0]    operation from ID/EX
//   reg1, reg2    rs1 (dividend/multiplicand), rs2 (divisor/multiplier)
//   stallreq      asks ctrl to hold IF..EX while an op is in flight
//   result        M-extension result, 0 outside DONE
//   result_valid  high in DONE
// Build option: define MDU_FAST_MUL_EN for a single-cycle multiplier (MUL state
// unused); otherwise multiplies iterate for 32 cycles like divides.
module ex_mdu
  import ex_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [7:0]  aluop,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  output logic        stallreq,
  output logic [31:0] result,
  output logic        result_valid
);

  mdu_state_e  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [7:0]  op_q, op_d;
  logic        neg_q, neg_d;       // negate the final value in DONE
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] acc_hi_q, acc_hi_d; // product upper half / running partial sum
  logic [31:0] acc_lo_q, acc_lo_d; // multiplier shifting out, product lower half
  logic        byp_q, byp_d;       // divide result came from a special case
  logic [31:0] byp_res_q, byp_res_d;

  logic        unused_stall;
  assign unused_stall = ^{stall[5:4], stall[2:0]};

  // Operand decode
  logic        s1, s2, neg_new, div_zero, div_ovf;
  logic [31:0] mag1, mag2;

  always_comb begin
    s1 = reg1[31] & ((aluop == EXE_MULH_OP) || (aluop == EXE_MULHSU_OP) ||
                     (aluop == EXE_DIV_OP) || (aluop == EXE_REM_OP));
    s2 = reg2[31] & ((aluop == EXE_MULH_OP) || (aluop == EXE_DIV_OP) ||
                     (aluop == EXE_REM_OP));
    mag1 = s1 ? (32'd0 - reg1) : reg1;
    mag2 = s2 ? (32'd0 - reg2) : reg2;
    // Remainder follows the dividend sign; everything else the sign product.
    neg_new = ((aluop == EXE_REM_OP) || (aluop == EXE_MULHSU_OP)) ? s1 : (s1 ^ s2);
    div_zero = (reg2 == 32'd0);
    div_ovf  = ((aluop == EXE_DIV_OP) || (aluop == EXE_REM_OP)) &&
               (reg1 == 32'h8000_0000) && (reg2 == 32'hffff_ffff);
  end

  // Shift-add multiplier step: add the multiplicand when the multiplier LSB is
  // set, then shift the {sum, acc_lo} pair right by one.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : 33'd0);

  // Divider
  logic        div_start, div_done;
  logic [31:0] div_quo, div_rem;

  mdu_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (mag1),
    .divisor   (mag2),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Sign-corrected final values
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s, done_result;

  always_comb begin
    prod_s = neg_q ? (64'd0 - {acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
    quo_s  = neg_q ? (32'd0 - div_quo) : div_quo;
    rem_s  = neg_q ? (32'd0 - div_rem) : div_rem;
    case (op_q)
      EXE_MUL_OP:                              done_result = prod_s[31:0];
      EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP: done_result = prod_s[63:32];
      EXE_DIV_OP, EXE_DIVU_OP:                 done_result = byp_q ? byp_res_q : quo_s;
      EXE_REM_OP, EXE_REMU_OP:                 done_result = byp_q ? byp_res_q : rem_s;
      default:                                 done_result = 32'd0;
    endcase
  end

  // FSM next state and outputs
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    op_d         = op_q;
    neg_d        = neg_q;
    mcand_d      = mcand_q;
    acc_hi_d     = acc_hi_q;
    acc_lo_d     = acc_lo_q;
    byp_d        = byp_q;
    byp_res_d    = byp_res_q;
    div_start    = 1'b0;
    stallreq     = 1'b0;
    result       = 32'd0;
    result_valid = 1'b0;

    case (state_q)
      StIdle: begin
        if (is_mul_op(aluop) || is_div_op(aluop)) begin
          stallreq  = 1'b1;
          op_d      = aluop;
          neg_d     = neg_new;
          count_d   = 5'd0;
          mcand_d   = mag1;
          acc_hi_d  = 32'd0;
          acc_lo_d  = mag2;
          byp_d     = 1'b0;
          byp_res_d = 32'd0;
          if (is_mul_op(aluop)) begin
`ifdef MDU_FAST_MUL_EN
            {acc_hi_d, acc_lo_d} = 64'(mag1) * 64'(mag2);
            state_d = StDone;
`else
            state_d = StMul;
`endif
          end else if (div_zero) begin
            byp_d     = 1'b1;
            byp_res_d = ((aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP)) ? 32'hffff_ffff
                                                                          : reg1;
            state_d   = StDone;
          end else if (div_ovf) begin
            byp_d     = 1'b1;
            byp_res_d = (aluop == EXE_DIV_OP) ? 32'h8000_0000 : 32'd0;
            state_d   = StDone;
          end else begin
            div_start = 1'b1;
            state_d   = StDiv;
          end
        end
      end
      StMul: begin
        stallreq = 1'b1;
        acc_hi_d = mul_sum[32:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
        count_d  = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = StDone;
        end
      end
      StDiv: begin
        stallreq = 1'b1;
        count_d  = count_q + 5'd1;
        if (div_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        result_valid = 1'b1;
        result       = done_result;
        if (!stall[StallEx]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= 5'd0;
      op_q      <= 8'd0;
      neg_q     <= 1'b0;
      mcand_q   <= 32'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      byp_q     <= 1'b0;
      byp_res_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      byp_q     <= byp_d;
      byp_res_q <= byp_res_d;
    end
  end

endmodule
